// File: rtl/pr_bus_arb.sv
// pr_bus_arb: two-master (m0 = CPU, m1 = DMA) round-robin arbiter in front of
// two small memory-mapped devices, with a fixed number of wait states per access.
// Ports: clk, rst (sync, active-high); per master: req/addr/we/wd in, rd/ack out;
//        grant/busy/err status; dev_addr/dev_wd/devN_we out to devices, devN_rd in.
module pr_bus_arb #(
   parameter int unsigned WAIT_CYC  = 1,
   parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
   parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic        m0_we,
   input  logic        m1_we,
   input  logic [31:0] m0_wd,
   input  logic [31:0] m1_wd,
   output logic [31:0] m0_rd,
   output logic [31:0] m1_rd,
   output logic        m0_ack,
   output logic        m1_ack,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        err,
   output logic [1:0]  dev_addr,
   output logic [31:0] dev_wd,
   output logic        dev0_we,
   output logic        dev1_we,
   input  logic [31:0] dev0_rd,
   input  logic [31:0] dev1_rd
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [2:0] WCNT_INIT = 3'(WAIT_CYC);

   state_t      state, state_nx;
   logic [2:0]  wcnt, wcnt_nx;
   logic        last, last_nx;   // 1: m1 was served last
   logic        owner, owner_nx; // 1: m1 owns the bus
   logic [31:0] addr_q, addr_nx;
   logic [31:0] wd_q, wd_nx;
   logic        we_q, we_nx;

   logic        pick;
   logic        sel0, sel1;
   logic        final_cyc;
   logic [31:0] rdata;

   // On a tie the master not served last wins; a lone request always wins.
   assign pick = (m0_req & m1_req) ? ~last : m1_req;

   assign sel0 = (addr_q >= DEV0_BASE) && (addr_q < DEV0_BASE + 32'd12);
   assign sel1 = (addr_q >= DEV1_BASE) && (addr_q < DEV1_BASE + 32'd12);

   assign final_cyc = (state == ACCESS) && (wcnt == 3'd0);

   always_comb begin
      rdata = 32'd0;
      if (sel0)
         rdata = dev0_rd;
      else if (sel1)
         rdata = dev1_rd;
   end

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      last_nx  = last;
      owner_nx = owner;
      addr_nx  = addr_q;
      wd_nx    = wd_q;
      we_nx    = we_q;
      unique case (state)
         IDLE: begin
            if (m0_req | m1_req) begin
               state_nx = ACCESS;
               wcnt_nx  = WCNT_INIT;
               owner_nx = pick;
               last_nx  = pick;
               addr_nx  = pick ? m1_addr : m0_addr;
               wd_nx    = pick ? m1_wd : m0_wd;
               we_nx    = pick ? m1_we : m0_we;
            end
         end
         ACCESS: begin
            if (wcnt == 3'd0)
               state_nx = RESP;
            else
               wcnt_nx = wcnt - 3'd1;
         end
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         wcnt   <= 3'd0;
         last   <= 1'b1;
         owner  <= 1'b0;
         addr_q <= 32'd0;
         wd_q   <= 32'd0;
         we_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         wcnt   <= wcnt_nx;
         last   <= last_nx;
         owner  <= owner_nx;
         addr_q <= addr_nx;
         wd_q   <= wd_nx;
         we_q   <= we_nx;
      end
   end

   // Read data lands on the final access edge; writes leave it untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rd <= 32'd0;
         m1_rd <= 32'd0;
      end else if (final_cyc && !we_q) begin
         if (owner)
            m1_rd <= rdata;
         else
            m0_rd <= rdata;
      end
   end

   assign busy     = (state != IDLE);
   assign grant    = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign dev_addr = busy ? addr_q[3:2] : 2'b00;
   assign dev_wd   = busy ? wd_q : 32'd0;
   assign dev0_we  = final_cyc & we_q & sel0;
   assign dev1_we  = final_cyc & we_q & sel1;
   assign m0_ack   = (state == RESP) & ~owner;
   assign m1_ack   = (state == RESP) & owner;
   assign err      = (state == RESP) & ~(sel0 | sel1);

endmodule

// File: tb/tb_pr_bus_arb.sv
// tb_pr_bus_arb: checks pr_bus_arb at WAIT_CYC = 1, 3 and 0 side by side
// against a transaction-level model of arbitration, decode and latency.
module tb_pr_bus_arb;

   localparam int WA = 1;
   localparam int WB = 3;
   localparam int WC = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m0_req = 1'b0, m1_req = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic m0_we = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_wd = '0, m1_wd = '0;

   logic [31:0] a_m0_rd, a_m1_rd, a_dev_wd, a_dev0_rd, a_dev1_rd;
   logic a_m0_ack, a_m1_ack, a_busy, a_err, a_dev0_we, a_dev1_we;
   logic [1:0] a_grant, a_dev_addr;
   logic [31:0] b_m0_rd, b_m1_rd, b_dev_wd, b_dev0_rd, b_dev1_rd;
   logic b_m0_ack, b_m1_ack, b_busy, b_err, b_dev0_we, b_dev1_we;
   logic [1:0] b_grant, b_dev_addr;
   logic [31:0] c_m0_rd, c_m1_rd, c_dev_wd, c_dev0_rd, c_dev1_rd;
   logic c_m0_ack, c_m1_ack, c_busy, c_err, c_dev0_we, c_dev1_we;
   logic [1:0] c_grant, c_dev_addr;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pr_bus_arb #(.WAIT_CYC(WA)) u_a (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_we(m0_we), .m1_we(m1_we),
      .m0_wd(m0_wd), .m1_wd(m1_wd),
      .m0_rd(a_m0_rd), .m1_rd(a_m1_rd),
      .m0_ack(a_m0_ack), .m1_ack(a_m1_ack),
      .grant(a_grant), .busy(a_busy), .err(a_err),
      .dev_addr(a_dev_addr), .dev_wd(a_dev_wd),
      .dev0_we(a_dev0_we), .dev1_we(a_dev1_we),
      .dev0_rd(a_dev0_rd), .dev1_rd(a_dev1_rd)
   );

   pr_bus_arb #(.WAIT_CYC(WB)) u_b (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_we(m0_we), .m1_we(m1_we),
      .m0_wd(m0_wd), .m1_wd(m1_wd),
      .m0_rd(b_m0_rd), .m1_rd(b_m1_rd),
      .m0_ack(b_m0_ack), .m1_ack(b_m1_ack),
      .grant(b_grant), .busy(b_busy), .err(b_err),
      .dev_addr(b_dev_addr), .dev_wd(b_dev_wd),
      .dev0_we(b_dev0_we), .dev1_we(b_dev1_we),
      .dev0_rd(b_dev0_rd), .dev1_rd(b_dev1_rd)
   );

   pr_bus_arb #(.WAIT_CYC(WC)) u_c (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_we(m0_we), .m1_we(m1_we),
      .m0_wd(m0_wd), .m1_wd(m1_wd),
      .m0_rd(c_m0_rd), .m1_rd(c_m1_rd),
      .m0_ack(c_m0_ack), .m1_ack(c_m1_ack),
      .grant(c_grant), .busy(c_busy), .err(c_err),
      .dev_addr(c_dev_addr), .dev_wd(c_dev_wd),
      .dev0_we(c_dev0_we), .dev1_we(c_dev1_we),
      .dev0_rd(c_dev0_rd), .dev1_rd(c_dev1_rd)
   );

   // Simple register-file devices behind instance a.
   logic [31:0] mem0 [4] = '{32'hA5A5_0000, 32'hA5A5_0001,
                             32'hA5A5_0002, 32'hA5A5_0003};
   logic [31:0] mem1 [4] = '{32'h5A5A_1000, 32'h5A5A_1001,
                             32'h5A5A_1002, 32'h5A5A_1003};
   assign a_dev0_rd = mem0[a_dev_addr];
   assign a_dev1_rd = mem1[a_dev_addr];
   always @(posedge clk) begin
      if (a_dev0_we) mem0[a_dev_addr] <= a_dev_wd;
      if (a_dev1_we) mem1[a_dev_addr] <= a_dev_wd;
   end

   assign b_dev0_rd = {30'h0, b_dev_addr};
   assign b_dev1_rd = {30'h1, b_dev_addr};
   assign c_dev0_rd = {30'h2, c_dev_addr};
   assign c_dev1_rd = {30'h3, c_dev_addr};

   // Reference model state
   logic [31:0] rmem [2][4];
   logic [31:0] rd_m [2];
   int last_m;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      if (a >= 32'h7F00 && a < 32'h7F0C) return 0;
      if (a >= 32'h7F10 && a < 32'h7F1C) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] edges [5];
      int k;
      edges = '{32'h7EFF, 32'h7F0C, 32'h7F0F, 32'h7F1C, 32'h1000};
      k = $urandom_range(0, 5);
      case (k)
         0, 1: return 32'h7F00 + 32'($urandom_range(0, 11));
         2, 3: return 32'h7F10 + 32'($urandom_range(0, 11));
         4: return edges[$urandom_range(0, 4)];
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_m = 1;
      rd_m[0] = 32'd0;
      rd_m[1] = 32'd0;
   endtask

   task automatic reset_chk(input string t, input logic [1:0] g,
                            input logic b, input logic a0, input logic a1,
                            input logic e, input logic w0, input logic w1,
                            input logic [31:0] r0, input logic [31:0] r1,
                            input logic [1:0] da);
      check({t, "_rst_grant"}, 32'(g), 32'd0);
      check({t, "_rst_busy"}, 32'(b), 32'd0);
      check({t, "_rst_ack"}, 32'({a1, a0}), 32'd0);
      check({t, "_rst_err"}, 32'(e), 32'd0);
      check({t, "_rst_we"}, 32'({w1, w0}), 32'd0);
      check({t, "_rst_m0rd"}, r0, 32'd0);
      check({t, "_rst_m1rd"}, r1, 32'd0);
      check({t, "_rst_daddr"}, 32'(da), 32'd0);
   endtask

   // Held requests: period w+3 (IDLE, w+1 ACCESS, RESP) from a fresh reset.
   task automatic hold_chk(input string t, input int w, input int c,
                           input bit r0, input bit r1, input logic [1:0] g,
                           input logic b, input logic a0, input logic a1);
      int per, p, k, own;
      logic [1:0] eg;
      per = w + 3;
      p = c % per;
      k = c / per;
      own = (r0 && r1) ? (k % 2) : (r1 ? 1 : 0);
      eg = (p == 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01);
      check({t, "_hold_grant"}, 32'(g), 32'(eg));
      check({t, "_hold_busy"}, 32'(b), 32'(p != 0));
      check({t, "_hold_ack0"}, 32'(a0), 32'(p == w + 2 && own == 0));
      check({t, "_hold_ack1"}, 32'(a1), 32'(p == w + 2 && own == 1));
   endtask

   task automatic hold_run(input bit r0, input bit r1, input int ncyc);
      m0_addr = 32'h7F04;
      m0_we = 1'b0;
      m1_addr = 32'h7F18;
      m1_we = 1'b0;
      m0_req = r0;
      m1_req = r1;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         hold_chk("a", WA, c, r0, r1, a_grant, a_busy, a_m0_ack, a_m1_ack);
         hold_chk("b", WB, c, r0, r1, b_grant, b_busy, b_m0_ack, b_m1_ack);
         hold_chk("c", WC, c, r0, r1, c_grant, c_busy, c_m0_ack, c_m1_ack);
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   // One arbitrated transfer on instance a; called just after a rising edge in IDLE.
   task automatic txn(input bit r0, input bit r1,
                      input logic [31:0] ad0, input bit we0, input logic [31:0] wd0,
                      input logic [31:0] ad1, input bit we1, input logic [31:0] wd1);
      int win, d, nwe0, nwe1, off;
      bit got, we;
      logic [31:0] ad, wd;
      m0_req = r0; m0_addr = ad0; m0_we = we0; m0_wd = wd0;
      m1_req = r1; m1_addr = ad1; m1_we = we1; m1_wd = wd1;
      win = (r0 && r1) ? ((last_m == 1) ? 0 : 1) : (r1 ? 1 : 0);
      last_m = win;
      ad = (win == 1) ? ad1 : ad0;
      wd = (win == 1) ? wd1 : wd0;
      we = (win == 1) ? we1 : we0;
      d = decode(ad);
      off = (d == 2) ? 0 : int'((ad - ((d == 1) ? 32'h7F10 : 32'h7F00)) / 4);
      @(negedge clk);
      check("idle_grant", 32'(a_grant), 32'd0);
      check("idle_busy", 32'(a_busy), 32'd0);
      check("idle_daddr", 32'(a_dev_addr), 32'd0);
      nwe0 = 0;
      nwe1 = 0;
      got = 1'b0;
      for (int n = 1; n <= WA + 6 && !got; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
         if (a_dev0_we) nwe0++;
         if (a_dev1_we) nwe1++;
         if (a_dev0_we || a_dev1_we) check("we_wd", a_dev_wd, wd);
         if (n <= WA + 1) begin
            check("acc_grant", 32'(a_grant), (win == 1) ? 32'd2 : 32'd1);
            check("acc_daddr", 32'(a_dev_addr), 32'(ad[3:2]));
         end
         if (a_m0_ack || a_m1_ack) begin
            got = 1'b1;
            check("ack_lat", 32'(n), 32'(WA + 2));
            check("ack_who", 32'({a_m1_ack, a_m0_ack}), (win == 1) ? 32'd2 : 32'd1);
            check("err", 32'(a_err), 32'(d == 2));
            if (!we) rd_m[win] = (d == 2) ? 32'd0 : rmem[d][off];
            check("m0_rd", a_m0_rd, rd_m[0]);
            check("m1_rd", a_m1_rd, rd_m[1]);
         end
      end
      check("ack_seen", 32'(got), 32'd1);
      check("we0_cnt", 32'(nwe0), 32'(we && d == 0));
      check("we1_cnt", 32'(nwe1), 32'(we && d == 1));
      if (we && d != 2) rmem[d][off] = wd;
      @(posedge clk); #1;
   endtask

   initial begin
      int nwe, nack;
      for (int i = 0; i < 4; i++) begin
         rmem[0][i] = 32'hA5A5_0000 + 32'(i);
         rmem[1][i] = 32'h5A5A_1000 + 32'(i);
      end
      do_reset();
      @(negedge clk);
      reset_chk("a", a_grant, a_busy, a_m0_ack, a_m1_ack, a_err,
                a_dev0_we, a_dev1_we, a_m0_rd, a_m1_rd, a_dev_addr);
      reset_chk("b", b_grant, b_busy, b_m0_ack, b_m1_ack, b_err,
                b_dev0_we, b_dev1_we, b_m0_rd, b_m1_rd, b_dev_addr);
      reset_chk("c", c_grant, c_busy, c_m0_ack, c_m1_ack, c_err,
                c_dev0_we, c_dev1_we, c_m0_rd, c_m1_rd, c_dev_addr);
      @(posedge clk); #1;

      // Directed: mapped read, mapped write, unmapped read, two ties.
      txn(1, 0, 32'h7F04, 0, 32'h0, 32'h0, 0, 32'h0);
      txn(0, 1, 32'h0, 0, 32'h0, 32'h7F14, 1, 32'h0000_00FF);
      txn(1, 0, 32'h1000, 0, 32'h0, 32'h0, 0, 32'h0);
      txn(1, 1, 32'h7F08, 0, 32'h0, 32'h7F14, 0, 32'h0);
      txn(1, 1, 32'h7F08, 0, 32'h0, 32'h7F14, 0, 32'h0);
      txn(1, 0, 32'h1004, 1, 32'h1234_5678, 32'h0, 0, 32'h0);

      for (int i = 0; i < 60; i++) begin
         int pat;
         pat = $urandom_range(1, 3);
         txn(pat[0], pat[1], rand_addr(), 1'($urandom), $urandom,
             rand_addr(), 1'($urandom), $urandom);
      end

      // Held requests on all three wait-state settings.
      do_reset();
      hold_run(1, 1, 20);
      do_reset();
      hold_run(1, 0, 14);
      do_reset();
      hold_run(0, 1, 8);

      // Reset on the second access cycle of a write (instance b, WAIT_CYC = 3).
      do_reset();
      m0_req = 1'b1;
      m0_addr = 32'h7F08;
      m0_we = 1'b1;
      m0_wd = 32'hDEAD_BEEF;
      nwe = 0;
      nack = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (n == 1) m0_req = 1'b0;
         if (n == 2) rst = 1'b1;
         if (n == 3) rst = 1'b0;
         @(negedge clk);
         if (b_dev0_we || b_dev1_we) nwe++;
         if (b_m0_ack || b_m1_ack) nack++;
         if (n == 2) check("abort_busy_pre", 32'(b_busy), 32'd1);
         if (n == 3) check("abort_busy", 32'(b_busy), 32'd0);
      end
      check("abort_we", 32'(nwe), 32'd0);
      check("abort_ack", 32'(nack), 32'd0);
      check("abort_m0rd", b_m0_rd, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pr_bus_arb.md
PR_BUS_ARB -- requirements
Module: pr_bus_arb

Interface
REQ-001 Parameter WAIT_CYC, default 1: device wait states per access, legal range 0..7.
REQ-002 Parameter DEV0_BASE, default 32'h0000_7F00: timer window base, 12 bytes.
REQ-003 Parameter DEV1_BASE, default 32'h0000_7F10: output-port window base, 12 bytes.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 m0_req, m1_req  in  1 each  access request; m0 = CPU, m1 = DMA.
REQ-007 m0_addr, m1_addr  in  32 each  byte address.
REQ-008 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-009 m0_wd, m1_wd  in  32 each  write data.
REQ-010 m0_rd, m1_rd  out  32 each  read data, registered per master.
REQ-011 m0_ack, m1_ack  out  1 each  one-cycle completion pulse.
REQ-012 grant  out  2  one-hot current owner; 2'b00 when idle.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 err  out  1  one-cycle pulse with ack on an unmapped address.
REQ-015 dev_addr  out  2  word offset, addr[3:2] of the granted master.
REQ-016 dev_wd  out  32  write data of the granted master.
REQ-017 dev0_we, dev1_we  out  1 each  device write strobes.
REQ-018 dev0_rd, dev1_rd  in  32 each  device read data, combinational from dev_addr.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP, with a 3-bit wait counter wcnt.
- IDLE: if any req is high, latch the winner's addr/we/wd, set grant, load wcnt = WAIT_CYC, and go to ACCESS.
- ACCESS: decrement wcnt each cycle; when wcnt == 0, go to RESP.
- RESP: go to IDLE.
REQ-020 Requests SHALL be sampled only in IDLE; req changes in other states are ignored.
REQ-021 Arbitration SHALL be round-robin on a 1-bit last-owner register.
- Both req high in IDLE: grant the master not last served.
- Single req: grant it regardless of last-owner.
- Update last-owner on entry to ACCESS.
REQ-022 Address decode, from the latched address:
- DEV0_BASE <= addr < DEV0_BASE+12 selects dev0.
- DEV1_BASE <= addr < DEV1_BASE+12 selects dev1.
- Any other address is unmapped.
REQ-023 devN_we SHALL pulse exactly once, on the final ACCESS cycle (wcnt == 0), only if the latched we = 1 and the address decodes to devN.
REQ-024 Read data SHALL be captured on the final ACCESS cycle into the owner's mN_rd.
- Unmapped read captures 0.
- A write leaves mN_rd unchanged.
- mN_rd holds until the next read by that master.
REQ-025 The owner's mN_ack SHALL pulse high for exactly the RESP cycle.
- err pulses in the same cycle if the address was unmapped.
- An unmapped write produces no devN_we.
REQ-026 Latency: req seen in IDLE at cycle t gives ack at t+WAIT_CYC+2. The next grant is possible at the earliest at t+WAIT_CYC+3.
REQ-027 dev_addr and dev_wd SHALL come from latched values. They are stable for the whole ACCESS phase and 0 in IDLE.
REQ-028 A master holding req high through RESP SHALL be treated as a new request in the following IDLE cycle. Round-robin still applies.

Reset
REQ-029 When rst is high at a clock edge, the next state SHALL be:
- state = IDLE, wcnt = 0, last-owner = m1 (so m0 wins the first tie);
- grant = 0, busy = 0;
- all ack, err and we = 0;
- m0_rd = m1_rd = 0.
REQ-030 Reset during ACCESS or RESP SHALL abort the transfer with no ack and no devN_we. rst has priority over every transition.

Verification
REQ-031 Reset, then m0 reads 0x7F04 with dev0_rd = 32'hA5A5_0001 and WAIT_CYC = 1 -> m0_ack at t+3, m0_rd = A5A5_0001, dev_addr = 2'b01 in ACCESS, no we.
REQ-032 m0 and m1 request together after reset -> m0 served first, then m1 with no idle gap other than RESP→IDLE; a second tie is granted to m0 again only after m1 has been served.
REQ-033 m1 writes 32'h0000_00FF to 0x7F14 -> dev1_we high for exactly one cycle; dev_wd = 0xFF; dev0_we stays 0; m1_ack follows the next cycle.
REQ-034 m0 reads 0x0000_1000 (unmapped) -> no devN_we, m0_rd = 0, err and m0_ack pulse together.
REQ-035 rst asserted on the second ACCESS cycle of a write with WAIT_CYC = 3 -> no dev*_we and no ack; busy = 0 on the next cycle.
REQ-036 With WAIT_CYC = 0, back-to-back m0 requests -> ack every 3 cycles; grant one-hot during ACCESS/RESP, 00 in IDLE.
